if_fetch_ctrl: RTL

- Instruction-fetch front end inside the CPU core, directly upstream of the inst-side SRAM-like port that the SRAM-to-AXI bridge consumes.
- Generates PCs and issues word reads with req/addr_ok/data_ok handshakes.
- Tracks in-flight requests and discards responses made stale by a redirect (branch/exception).
- Buffers returned {pc, inst} pairs for the decode stage with valid/ready back-pressure.

---
 rtl/if_fetch_ctrl_pkg.sv | 10 +
 rtl/if_fetch_ctrl_if.sv | 22 ++
 rtl/if_fetch_ctrl_fetch_fifo.sv | 63 ++++++
 rtl/if_fetch_ctrl.sv | 119 +++++++++++
 4 files changed

// File: rtl/if_fetch_ctrl_pkg.sv
// Shared definitions for the instruction-fetch front end.
package if_fetch_ctrl_pkg;
    localparam logic [31:0] RESET_PC  = 32'hbfc00000;
    localparam logic [1:0]  SIZE_WORD = 2'b10;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/if_fetch_ctrl_if.sv
// SRAM-like instruction port between the fetch unit (master) and the AXI bridge (slave).
interface if_fetch_ctrl_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/if_fetch_ctrl_fetch_fifo.sv
// Small synchronous FIFO with flush; flush overrides push and pop in the same cycle.
module fetch_fifo #(
    parameter int  DEPTH = 2,
    parameter int  W     = 32,
    localparam int CW    = $clog2(DEPTH + 1),
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count
);
    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_en, pop_en;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        pop_en   = pop & (count_q != '0);
        push_en  = push & ((int'(count_q) < DEPTH) | pop_en);
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (pop_en)  rd_ptr_d = ptr_inc(rd_ptr_q);
            if (push_en) wr_ptr_d = ptr_inc(wr_ptr_q);
            count_d = count_q + CW'(push_en) - CW'(pop_en);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: nothing is read until count says it was written.
    always_ff @(posedge clk) begin
        if (push_en & ~flush) mem_q[wr_ptr_q] <= push_data;
    end

    assign head  = mem_q[rd_ptr_q];
    assign count = count_q;
endmodule

// File: rtl/if_fetch_ctrl.sv
// Fetch front end: issues word reads, drops responses orphaned by redirects, buffers {pc, inst} for decode.
module if_fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = if_fetch_ctrl_pkg::RESET_PC,
    parameter int          MAX_INFLIGHT = 2,
    parameter int          BUF_DEPTH    = 2
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            redirect_valid,
    input  logic [31:0]     redirect_pc,
    if_fetch_ctrl_if.master inst_sram,
    output logic            out_valid,
    output logic [31:0]     out_pc,
    output logic [31:0]     out_inst,
    input  logic            out_ready
);
    import if_fetch_ctrl_pkg::*;

    localparam int IW  = $clog2(MAX_INFLIGHT + 1);
    localparam int OCW = $clog2(BUF_DEPTH + 1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   addr_q, addr_d;
    logic          pending_q, pending_d;
    logic          stale_q, stale_d;
    logic          run_q, run_d;
    logic [IW-1:0] inflight_q, inflight_d;
    logic [IW-1:0] discard_q, discard_d;

    logic          fetch_pc_ok, issue_new, req, accept, drop, live_ret;
    logic [31:0]   addr;
    logic [31:0]   pcq_head;
    logic [IW-1:0] pcq_count;
    logic [OCW-1:0] out_count;
    fetch_entry_t  push_entry, head_entry;

    always_comb begin
        // Credit counts only live requests; discarded ones never reach the buffer.
        fetch_pc_ok = run_q & ~stale_q & ~redirect_valid;
        issue_new   = fetch_pc_ok
                    & (int'(inflight_q) < MAX_INFLIGHT)
                    & ((int'(inflight_q) - int'(discard_q) + int'(out_count)) < BUF_DEPTH);
        req         = pending_q | issue_new;
        addr        = pending_q ? addr_q : fetch_pc_q;
        accept      = req & inst_sram.addr_ok;
        drop        = inst_sram.data_ok & (discard_q != '0);
        live_ret    = inst_sram.data_ok & ~drop & (pcq_count != '0);

        run_d      = 1'b1;
        pending_d  = req & ~inst_sram.addr_ok;
        addr_d     = addr;
        stale_d    = pending_d & (redirect_valid | stale_q);
        inflight_d = inflight_q + IW'(accept) - IW'(inst_sram.data_ok);
        discard_d  = discard_q + IW'(accept & stale_q) - IW'(drop);
        fetch_pc_d = fetch_pc_q;
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            discard_d  = inflight_d;
        end else if (accept & ~stale_q) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end

        push_entry.pc   = pcq_head;
        push_entry.inst = inst_sram.rdata;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
            pending_q  <= 1'b0;
            stale_q    <= 1'b0;
            run_q      <= 1'b0;
            inflight_q <= '0;
            discard_q  <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
            pending_q  <= pending_d;
            stale_q    <= stale_d;
            run_q      <= run_d;
            inflight_q <= inflight_d;
            discard_q  <= discard_d;
        end
    end

    fetch_fifo #(.DEPTH(MAX_INFLIGHT), .W(32)) u_pc_queue (
        .clk       (clk),
        .rst_n     (resetn),
        .flush     (redirect_valid),
        .push      (accept & ~stale_q),
        .push_data (addr),
        .pop       (live_ret),
        .head      (pcq_head),
        .count     (pcq_count)
    );

    fetch_fifo #(.DEPTH(BUF_DEPTH), .W($bits(fetch_entry_t))) u_out_buf (
        .clk       (clk),
        .rst_n     (resetn),
        .flush     (redirect_valid),
        .push      (live_ret),
        .push_data (push_entry),
        .pop       (out_valid & out_ready),
        .head      (head_entry),
        .count     (out_count)
    );

    assign inst_sram.req   = req;
    assign inst_sram.addr  = addr;
    assign inst_sram.wr    = 1'b0;
    assign inst_sram.size  = SIZE_WORD;
    assign inst_sram.wstrb = 4'b0000;
    assign inst_sram.wdata = 32'd0;

    assign out_valid = (out_count != '0);
    assign out_pc    = out_valid ? head_entry.pc   : 32'd0;
    assign out_inst  = out_valid ? head_entry.inst : 32'd0;
endmodule
